// File: rtl/counter_3bit_seq.sv
// Sequenced 3-bit accumulator driving an external 3-bit adder; stepping is
// started/stopped by a small IDLE/RUN/HALT controller.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not counting; adder B operand forced to zero
//   RUN     | one add of step_q per cycle using the external adder result
//   HALT    | carry seen with wrap disabled; acc frozen until restart/stop
module counter_3bit_seq #(
    parameter logic [2:0] TERMINAL = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic [2:0] step,
    input  logic       wrap_en,
    output logic       a2,
    output logic       a1,
    output logic       a0,
    output logic       b2,
    output logic       b1,
    output logic       b0,
    input  logic       s2,
    input  logic       s1,
    input  logic       s0,
    input  logic       cout,
    output logic [2:0] count,
    output logic       busy,
    output logic       ovf,
    output logic       tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] acc_q, acc_d;
    logic [2:0] step_q, step_d;
    logic       ovf_q, ovf_d;
    logic       tc_q, tc_d;
    logic [2:0] sum;

    assign sum = {s2, s1, s0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 3'd0;
            step_q  <= 3'd0;
            ovf_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            ovf_q   <= ovf_d;
            tc_q    <= tc_d;
        end
    end

    // Load overrides everything; in IDLE/HALT a simultaneous stop beats start.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stop)                   state_d = ST_IDLE;
                    else if (cout && !wrap_en)  state_d = ST_HALT;
                end
                ST_HALT: begin
                    if (stop)       state_d = ST_IDLE;
                    else if (start) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d  = acc_q;
        step_d = step_q;
        ovf_d  = ovf_q;
        tc_d   = 1'b0;
        if (load) begin
            acc_d = load_val;
            ovf_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) step_d = step;
                end
                ST_RUN: begin
                    if (!stop) begin
                        if (!cout) begin
                            acc_d = sum;
                        end else begin
                            ovf_d = 1'b1;
                            if (wrap_en) acc_d = sum;
                        end
                        // Pulse only on a real change into TERMINAL, so step 0 never fires.
                        tc_d = (acc_d != acc_q) && (acc_d == TERMINAL);
                    end
                end
                ST_HALT: begin
                    if (start && !stop) begin
                        ovf_d  = 1'b0;
                        step_d = step;
                    end
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    always_comb begin
        busy         = (state_q == ST_RUN);
        {a2, a1, a0} = acc_q;
        {b2, b1, b0} = busy ? step_q : 3'b000;
        count        = acc_q;
        ovf          = ovf_q;
        tc           = tc_q;
    end

endmodule

// File: tb/tb_counter_3bit_seq.sv
// Bench for counter_3bit_seq: directed scenarios then random stimulus, checked
// against an arithmetic reference model; the external adder is modelled here.
module tb_counter_3bit_seq;

    localparam int TERM    = 7;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_HALT  = 2;

    logic       clk;
    logic       rst_n;
    logic       start, stop, load, wrap_en;
    logic [2:0] load_val, step;
    logic       a2, a1, a0, b2, b1, b0;
    logic       s2, s1, s0, cout;
    logic [2:0] count;
    logic       busy, ovf, tc;
    logic [3:0] add_sum;

    int total = 0;
    int bad   = 0;

    int m_acc, m_step, m_ovf, m_tc, m_ph;

    counter_3bit_seq #(.TERMINAL(3'd7)) dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .stop(stop), .load(load),
        .load_val(load_val), .step(step), .wrap_en(wrap_en),
        .a2(a2), .a1(a1), .a0(a0),
        .b2(b2), .b1(b1), .b0(b0),
        .s2(s2), .s1(s1), .s0(s0), .cout(cout),
        .count(count), .busy(busy), .ovf(ovf), .tc(tc)
    );

    assign add_sum = {1'b0, a2, a1, a0} + {1'b0, b2, b1, b0};
    assign {cout, s2, s1, s0} = add_sum;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_step = 0; m_ovf = 0; m_tc = 0; m_ph = P_IDLE;
    endtask

    task automatic model_next();
        int sum, nxt;
        if (load) begin
            m_acc = int'(load_val); m_ovf = 0; m_tc = 0; m_ph = P_IDLE;
        end else begin
            m_tc = 0;
            case (m_ph)
                P_IDLE: if (start && !stop) begin m_step = int'(step); m_ph = P_RUN; end
                P_RUN: begin
                    if (stop) m_ph = P_IDLE;
                    else begin
                        sum = m_acc + m_step;
                        nxt = m_acc;
                        if (sum >= 8) begin
                            m_ovf = 1;
                            if (wrap_en) nxt = sum - 8;
                            else m_ph = P_HALT;
                        end else nxt = sum;
                        m_tc  = (nxt != m_acc && nxt == TERM) ? 1 : 0;
                        m_acc = nxt;
                    end
                end
                P_HALT: begin
                    if (stop) m_ph = P_IDLE;
                    else if (start) begin m_ovf = 0; m_step = int'(step); m_ph = P_RUN; end
                end
                default: m_ph = P_IDLE;
            endcase
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(m_acc));
        chk("busy",  32'(busy),  32'((m_ph == P_RUN) ? 1 : 0));
        chk("ovf",   32'(ovf),   32'(m_ovf));
        chk("tc",    32'(tc),    32'(m_tc));
        chk("a_op",  32'({a2, a1, a0}), 32'(m_acc));
        chk("b_op",  32'({b2, b1, b0}), 32'((m_ph == P_RUN) ? m_step : 0));
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Pulse reset between edges and confirm it takes effect before the next edge.
    task automatic mid_cycle_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
    endtask

    int exp34 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        start = 0; stop = 0; load = 0; load_val = 0; step = 0; wrap_en = 0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Wrapping count 0..7,0,1 with tc at 7 and ovf after the wrap
        start = 1; step = 3'd1; wrap_en = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("seq_count", 32'(count), 32'(exp34[i]));
            chk("seq_tc",    32'(tc),    32'((i == 7) ? 1 : 0));
            chk("seq_ovf",   32'(ovf),   32'((i >= 8) ? 1 : 0));
        end
        start = 0; stop = 1; tick(); stop = 0;

        // Load 5, step 2 without wrap -> 7 then halt on carry
        load = 1; load_val = 3'd5; tick(); load = 0;
        start = 1; step = 3'd2; wrap_en = 0; tick();
        chk("halt_run_busy", 32'(busy), 32'd1);
        start = 0; tick();
        chk("halt_at7", 32'(count), 32'd7);
        chk("halt_tc",  32'(tc),    32'd1);
        tick();
        chk("halt_count", 32'(count), 32'd7);
        chk("halt_ovf",   32'(ovf),   32'd1);
        chk("halt_busy",  32'(busy),  32'd0);
        chk("halt_b",     32'({b2, b1, b0}), 32'd0);

        // Restart from HALT clears ovf, then halts again on the next carry
        start = 1; step = 3'd1; tick(); start = 0;
        chk("restart_ovf",  32'(ovf),  32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        tick();
        chk("rehalt_ovf",  32'(ovf),  32'd1);
        chk("rehalt_busy", 32'(busy), 32'd0);
        stop = 1; tick(); stop = 0;
        chk("halt_stop_ovf_kept", 32'(ovf), 32'd1);

        // start+stop together in IDLE, then load during RUN
        start = 1; stop = 1; tick(); stop = 0;
        chk("startstop_busy", 32'(busy), 32'd0);
        tick(); start = 0;
        load = 1; load_val = 3'd3; tick(); load = 0;
        chk("load_count", 32'(count), 32'd3);
        chk("load_busy",  32'(busy),  32'd0);
        chk("load_ovf",   32'(ovf),   32'd0);

        // Async reset mid-run at count 4, no counting afterwards without start
        start = 1; step = 3'd1; wrap_en = 0; tick(); start = 0;
        tick();
        chk("pre_rst_count", 32'(count), 32'd4);
        mid_cycle_reset();
        chk("rst_count", 32'(count), 32'd0);
        repeat (3) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Zero step: runs but never moves, carries, or pulses tc
        start = 1; step = 3'd0; tick(); start = 0;
        repeat (5) tick();
        chk("zero_busy", 32'(busy), 32'd1);
        chk("zero_tc",   32'(tc),   32'd0);
        stop = 1; tick(); stop = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            load     = ($urandom % 16) == 0;
            stop     = ($urandom % 8) == 0;
            start    = ($urandom % 3) == 0;
            load_val = 3'($urandom);
            step     = 3'($urandom);
            wrap_en  = 1'($urandom);
            if (($urandom % 60) == 0) begin
                @(posedge clk); #1;
                model_next();
                check_all();
                mid_cycle_reset();
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_3bit_seq.md
COUNTER_3BIT_SEQ -- requirements
Module: counter_3bit_seq

Interface
REQ-001 Parameter TERMINAL, default 3'd7, SHALL set the count value that raises tc.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request counting (level-sampled each edge).
REQ-005 stop  input  1  SHALL request return to idle.
REQ-006 load  input  1  SHALL request a synchronous load of load_val.
REQ-007 load_val  input  3  SHALL be the value written to the accumulator on load.
REQ-008 step  input  3  SHALL be the increment, captured on the start edge.
REQ-009 wrap_en  input  1  SHALL select wrap (1) or halt (0) on adder carry-out.
REQ-010 a2, a1, a0  output  1 each  SHALL drive the accumulator value to the downstream 3-bit adder A operand.
REQ-011 b2, b1, b0  output  1 each  SHALL drive the adder B operand.
REQ-012 s2, s1, s0, cout  input  1 each  SHALL return the adder sum and carry (combinational, same cycle).
REQ-013 count  output  3  SHALL equal the accumulator register.
REQ-014 busy  output  1  SHALL be 1 exactly when state is RUN.
REQ-015 ovf  output  1  SHALL be a sticky carry-out flag.
REQ-016 tc  output  1  SHALL be a one-cycle registered terminal-count pulse.

Function
REQ-017 The block SHALL hold a 3-bit accumulator acc, 3-bit step_q, state in {IDLE, RUN, HALT}, ovf, tc registers.
REQ-018 {a2,a1,a0} SHALL equal acc combinationally at all times.
REQ-019 {b2,b1,b0} SHALL equal step_q in RUN and 3'b000 in IDLE and HALT.
REQ-020 load SHALL take priority in every state: acc<=load_val, ovf<=0, tc<=0, state<=IDLE, step_q unchanged.
REQ-021 IDLE, start=1, stop=0: SHALL set step_q<=step, state<=RUN, acc unchanged (first add occurs next cycle).
REQ-022 IDLE with start=1 and stop=1 simultaneously: stop SHALL win; state stays IDLE, nothing captured.
REQ-023 RUN, stop=1: SHALL go to IDLE with acc unchanged (no add that cycle); start ignored.
REQ-024 RUN, stop=0, cout=0: acc<={s2,s1,s0}, one add per cycle, latency one cycle from operand to count.
REQ-025 RUN, cout=1, wrap_en=1: acc<={s2,s1,s0} (modulo-8 wrap), ovf<=1, remain RUN.
REQ-026 RUN, cout=1, wrap_en=0: acc unchanged, ovf<=1, state<=HALT.
REQ-027 HALT, start=1 and stop=0: ovf<=0, step_q<=step, state<=RUN; stop=1 SHALL go to IDLE with ovf retained.
REQ-028 ovf SHALL only be cleared by reset, load, or HALT->RUN restart.
REQ-029 tc SHALL be 1 for exactly the cycle after an acc update in RUN whose new value equals TERMINAL and differs from the old value; 0 otherwise.
REQ-030 step_q=0 in RUN SHALL leave acc constant, never carry, and never pulse tc.
REQ-031 Widths SHALL be strictly 3 bits; no internal wider arithmetic; sum comes only from the adder inputs.

Reset
REQ-032 rst_n=0 SHALL immediately (asynchronously) force acc=0, step_q=0, state=IDLE, ovf=0, tc=0, hence count=0, busy=0, a*=0, b*=0.
REQ-033 Reset asserted mid-RUN SHALL abort the run with no further add; release SHALL resume in IDLE requiring a new start.

Verification
REQ-034 Reset, start=1 step=1 wrap_en=1, 10 cycles -> count 0,1,..,7,0,1; ovf=1 from the 0 after 7; tc pulse the cycle count becomes 7.
REQ-035 load_val=5 load=1, then start step=2 wrap_en=0 -> count 5->7, next edge cout=1: count stays 7, ovf=1, busy=0 (HALT), b*=0.
REQ-036 From HALT, start=1 step=1 -> ovf clears, busy=1, count 7 with wrap_en=0 halts again next cycle, ovf=1.
REQ-037 IDLE, start=1 and stop=1 same edge -> busy stays 0, count unchanged; then load=1 asserted during RUN with load_val=3 -> count=3, busy=0, ovf=0.
REQ-038 RUN at count=4, rst_n pulsed low mid-cycle -> count=0, busy=0, ovf=0 before next edge; no counting after release until start.
REQ-039 start with step=0 -> busy=1, count constant, tc never pulses, ovf stays 0.
